// File: rtl/uart_boot_loader.sv
// Loads a framed byte stream (A5, N lo/hi, 4N payload bytes) into bram as 32-bit words; write pulse one cycle after 4th byte; no backpressure, bytes outside a frame are dropped.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_boot_loader #(
  parameter int DEPTH          = 128,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_write_enable,
  output logic [3:0]        mem_mask_write,
  output logic [ADDR_W-1:0] mem_addr_write,
  output logic [31:0]       mem_data_in,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0]       DEPTH16  = 16'(DEPTH);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        MAGIC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         len_lo, len_lo_nxt;
  logic [15:0]        word_count, word_count_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [23:0]        word_buf, word_buf_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               we_nxt;
  logic [3:0]         mask_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [31:0]        data_nxt;
  logic               cpu_reset_nxt, done_nxt, error_nxt;
  logic [15:0]        words_nxt;
  logic [15:0]        frame_len;
  logic               timer_active;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum, csum_nxt;
`endif

  assign frame_len = {rx_data, len_lo};

  always_comb begin
    timer_active = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    timer_active = timer_active || (state == S_CHECK);
`endif
  end

  always_comb begin
    state_nxt      = state;
    len_lo_nxt     = len_lo;
    word_count_nxt = word_count;
    byte_idx_nxt   = byte_idx;
    word_buf_nxt   = word_buf;
    timer_nxt      = (timer_active && !rx_valid) ? timer + 1'b1 : '0;
    we_nxt         = 1'b0;
    mask_nxt       = 4'b0000;
    addr_nxt       = mem_addr_write;
    data_nxt       = mem_data_in;
    cpu_reset_nxt  = cpu_reset;
    done_nxt       = done;
    error_nxt      = error;
    words_nxt      = words_loaded;
`ifdef LOADER_CHECKSUM_EN
    csum_nxt       = csum;
`endif

    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == MAGIC) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_lo_nxt = rx_data;
          state_nxt  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (frame_len == 16'd0 || frame_len > DEPTH16) begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end else begin
            state_nxt      = S_DATA;
            word_count_nxt = frame_len;
            words_nxt      = 16'd0;
            byte_idx_nxt   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_nxt       = 8'h00;
`endif
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          byte_idx_nxt = byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_nxt     = csum ^ rx_data;
`endif
          if (byte_idx == 2'd3) begin
            we_nxt    = 1'b1;
            mask_nxt  = 4'b1111;
            addr_nxt  = words_loaded[ADDR_W-1:0];
            data_nxt  = {rx_data, word_buf};
            words_nxt = words_loaded + 16'd1;
            // Last word: leave DATA on the same edge that raises the write pulse
            if (words_loaded + 16'd1 == word_count) begin
`ifdef LOADER_CHECKSUM_EN
              state_nxt     = S_CHECK;
`else
              state_nxt     = S_RUN;
              cpu_reset_nxt = 1'b0;
              done_nxt      = 1'b1;
`endif
            end
          end else begin
            word_buf_nxt = {rx_data, word_buf[23:8]};
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            state_nxt     = S_RUN;
            cpu_reset_nxt = 1'b0;
            done_nxt      = 1'b1;
          end else begin
            state_nxt = S_ERROR;
            error_nxt = 1'b1;
          end
        end
      end
`endif
      S_RUN: begin
        state_nxt = S_RUN;
      end
      S_ERROR: begin
        if (rx_valid && rx_data == MAGIC) begin
          state_nxt = S_LEN_LO;
          error_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Timeout only fires on a cycle with no byte, so it never races a case transition above
    if (timer_active && !rx_valid && timer == TMR_LAST) begin
      state_nxt = S_ERROR;
      error_nxt = 1'b1;
      timer_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      len_lo           <= 8'h00;
      word_count       <= 16'd0;
      byte_idx         <= 2'd0;
      word_buf         <= 24'h0;
      timer            <= '0;
      mem_write_enable <= 1'b0;
      mem_mask_write   <= 4'b0000;
      mem_addr_write   <= '0;
      mem_data_in      <= 32'h0;
      cpu_reset        <= 1'b1;
      done             <= 1'b0;
      error            <= 1'b0;
      words_loaded     <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum             <= 8'h00;
`endif
    end else begin
      state            <= state_nxt;
      len_lo           <= len_lo_nxt;
      word_count       <= word_count_nxt;
      byte_idx         <= byte_idx_nxt;
      word_buf         <= word_buf_nxt;
      timer            <= timer_nxt;
      mem_write_enable <= we_nxt;
      mem_mask_write   <= mask_nxt;
      mem_addr_write   <= addr_nxt;
      mem_data_in      <= data_nxt;
      cpu_reset        <= cpu_reset_nxt;
      done             <= done_nxt;
      error            <= error_nxt;
      words_loaded     <= words_nxt;
`ifdef LOADER_CHECKSUM_EN
      csum             <= csum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frames, junk bytes, bad lengths, timeout, checksum and async reset.
module tb_uart_boot_loader;

  localparam int TMO = 40;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_write_enable;
  logic [3:0]  mem_mask_write;
  logic [6:0]  mem_addr_write;
  logic [31:0] mem_data_in;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  seq [$];
  logic [6:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_mask [$];

  uart_boot_loader #(.DEPTH(128), .ADDR_W(7), .TIMEOUT_CYCLES(TMO)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .mem_write_enable (mem_write_enable),
    .mem_mask_write   (mem_mask_write),
    .mem_addr_write   (mem_addr_write),
    .mem_data_in      (mem_data_in),
    .cpu_reset        (cpu_reset),
    .done             (done),
    .error            (error),
    .words_loaded     (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_write_enable === 1'b1) begin
      wr_addr.push_back(mem_addr_write);
      wr_data.push_back(mem_data_in);
      wr_mask.push_back(mem_mask_write);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives seq, one byte per cycle plus gap idle cycles between bytes
  task automatic send_seq(input int gap);
    foreach (seq[i]) begin
      rx_data  = seq[i];
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    wr_mask.delete();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] x;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_we", mem_write_enable, 0);
    check("rst_words", words_loaded, 0);
    check("rst_mask", mem_mask_write, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Test 1: two-word frame, back-to-back bytes (next byte lands in the write-pulse cycle)
    seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_seq(0);
    idle(2);
    check("t1_nwr", wr_data.size(), 2);
    check("t1_addr0", wr_addr[0], 0);
    check("t1_data0", wr_data[0], 32'h44332211);
    check("t1_addr1", wr_addr[1], 1);
    check("t1_data1", wr_data[1], 32'h88776655);
    check("t1_mask", wr_mask[1], 4'hF);
    check("t1_words", words_loaded, 2);
    check("t1_done", done, 1);
    check("t1_cpu_reset", cpu_reset, 0);
    check("t1_error", error, 0);

    // Test 2: junk before magic, bytes spaced out
    do_reset();
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_seq(2);
    idle(2);
    check("t2_nwr", wr_data.size(), 2);
    check("t2_data0", wr_data[0], 32'h44332211);
    check("t2_data1", wr_data[1], 32'h88776655);
    check("t2_done", done, 1);

    // Test 3: N=129 and N=0 rejected, then a good one-word frame
    do_reset();
    seq = '{8'hA5, 8'h81, 8'h00};
    send_seq(0);
    check("t3_err129", error, 1);
    check("t3_cpu_reset", cpu_reset, 1);
    seq = '{8'hA5, 8'h00, 8'h00};
    send_seq(0);
    check("t3_err0", error, 1);
    idle(2);
    check("t3_nwr_bad", wr_data.size(), 0);
    seq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_seq(0);
    idle(2);
    check("t3_err_clr", error, 0);
    check("t3_data", wr_data[0], 32'h12345678);
    check("t3_done", done, 1);

    // N = DEPTH: full memory, last address 127
    do_reset();
    seq = '{8'hA5, 8'h80, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 512; i++) begin
      b = 8'(i);
      seq.push_back(b);
      x = x ^ b;
    end
    seq.push_back(x);
    send_seq(0);
    idle(2);
    check("tmax_nwr", wr_data.size(), 128);
    check("tmax_data0", wr_data[0], 32'h03020100);
    check("tmax_addr_last", wr_addr[127], 127);
    check("tmax_data_last", wr_data[127], 32'hFFFEFDFC);
    check("tmax_words", words_loaded, 128);
    check("tmax_done", done, 1);

    // Test 4: stall mid-word until timeout, then retry
    do_reset();
    seq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE};
    send_seq(0);
    idle(TMO - 3);
    check("t4_no_early_tmo", error, 0);
    idle(8);
    check("t4_tmo_err", error, 1);
    check("t4_nwr", wr_data.size(), 0);
    check("t4_cpu_reset", cpu_reset, 1);
    seq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_seq(1);
    idle(2);
    check("t4_data", wr_data[0], 32'hDEADBEEF);
    check("t4_done", done, 1);
    check("t4_error", error, 0);

    // Test 5: wrong checksum byte
    do_reset();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    send_seq(0);
    idle(2);
    check("t5_nwr", wr_data.size(), 2);
`ifdef LOADER_CHECKSUM_EN
    check("t5_error", error, 1);
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_done", done, 0);
`else
    check("t5_error", error, 0);
    check("t5_cpu_reset", cpu_reset, 0);
    check("t5_done", done, 1);
`endif

    // Test 6: async reset mid-DATA between clock edges
    do_reset();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_seq(0);
    check("t6_words_pre", words_loaded, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_we", mem_write_enable, 0);
    check("t6_cpu_reset", cpu_reset, 1);
    check("t6_words", words_loaded, 0);
    check("t6_mask", mem_mask_write, 0);
    check("t6_data", mem_data_in, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    wr_mask.delete();
    @(negedge clock);
    seq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_seq(0);
    idle(2);
    check("t6_nwr", wr_data.size(), 2);
    check("t6_data1", wr_data[1], 32'h88776655);
    check("t6_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
